// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller and its register file.
// Status register bits are stored as {N,Z,C}.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam int REG_AW = 5;

    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_N = 2;

    // Wide enough to count up to the largest supported ALU latency (7)
    localparam int CNT_W = 3;

endpackage

// File: rtl/alu_issue_regfile.sv
// 32x8 register file: two operand read ports, one debug read port, and
// write-back ports that take priority over the external preload port.
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [7:0]        rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [7:0]        rd_data_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data,
    input  logic              wb_lo_we,
    input  logic [REG_AW-1:0] wb_lo_addr,
    input  logic [7:0]        wb_lo_data,
    input  logic              wb_hi_we,
    input  logic [REG_AW-1:0] wb_hi_addr,
    input  logic [7:0]        wb_hi_data,
    input  logic              ext_we,
    input  logic [REG_AW-1:0] ext_addr,
    input  logic [7:0]        ext_data
);

    logic [7:0] mem_q [NREGS];
    logic [7:0] mem_d [NREGS];

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];
    assign dbg_data  = mem_q[dbg_addr];

    // Later assignments win, so write-back overrides a colliding ext write
    always_comb begin
        mem_d = mem_q;
        if (ext_we) begin
            mem_d[ext_addr] = ext_data;
        end
        if (wb_lo_we) begin
            mem_d[wb_lo_addr] = wb_lo_data;
        end
        if (wb_hi_we) begin
            mem_d[wb_hi_addr] = wb_hi_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external ALU, waits its latency,
// then writes the result back to the register file and status flags.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rr,
    input  logic              instr_wide,
    input  logic              instr_flags_en,
    output logic [7:0]        alu_data_rd,
    output logic [7:0]        alu_data_rr,
    output logic              alu_ci,
    output logic [7:0]        alu_opcode,
    input  logic [15:0]       alu_data_o,
    input  logic              alu_co,
    input  logic              alu_zo,
    input  logic              alu_no,
    output logic              done,
    input  logic              ext_we,
    input  logic [REG_AW-1:0] ext_waddr,
    input  logic [7:0]        ext_wdata,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data,
    output logic [2:0]        dbg_sreg
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        alu_data_rd_q, alu_data_rd_d;
    logic [7:0]        alu_data_rr_q, alu_data_rr_d;
    logic              alu_ci_q, alu_ci_d;
    logic [7:0]        alu_opcode_q, alu_opcode_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wide_q, wide_d;
    logic              flags_en_q, flags_en_d;
    logic [2:0]        sreg_q, sreg_d;

    logic              accept;
    logic              wb_active;
    logic [7:0]        op_rd_data;
    logic [7:0]        op_rr_data;
    logic [REG_AW-1:0] wb_hi_addr;

    assign wb_hi_addr = rd_q + REG_AW'(1);

    alu_issue_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_a  (instr_rd),
        .rd_data_a  (op_rd_data),
        .rd_addr_b  (instr_rr),
        .rd_data_b  (op_rr_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .wb_lo_we   (wb_active),
        .wb_lo_addr (rd_q),
        .wb_lo_data (alu_data_o[7:0]),
        .wb_hi_we   (wb_active & wide_q),
        .wb_hi_addr (wb_hi_addr),
        .wb_hi_data (alu_data_o[15:8]),
        .ext_we     (ext_we),
        .ext_addr   (ext_waddr),
        .ext_data   (ext_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            alu_data_rd_q <= '0;
            alu_data_rr_q <= '0;
            alu_ci_q      <= 1'b0;
            alu_opcode_q  <= '0;
            rd_q          <= '0;
            wide_q        <= 1'b0;
            flags_en_q    <= 1'b0;
            sreg_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_data_rd_q <= alu_data_rd_d;
            alu_data_rr_q <= alu_data_rr_d;
            alu_ci_q      <= alu_ci_d;
            alu_opcode_q  <= alu_opcode_d;
            rd_q          <= rd_d;
            wide_q        <= wide_d;
            flags_en_q    <= flags_en_d;
            sreg_q        <= sreg_d;
        end
    end

    // WAIT lasts exactly ALU_LAT cycles before moving to write-back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(ALU_LAT - 1)) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        alu_data_rd_d = alu_data_rd_q;
        alu_data_rr_d = alu_data_rr_q;
        alu_ci_d      = alu_ci_q;
        alu_opcode_d  = alu_opcode_q;
        rd_d          = rd_q;
        wide_d        = wide_q;
        flags_en_d    = flags_en_q;
        sreg_d        = sreg_q;
        if (accept) begin
            alu_data_rd_d = op_rd_data;
            alu_data_rr_d = op_rr_data;
            alu_ci_d      = sreg_q[SREG_C];
            alu_opcode_d  = instr_op;
            rd_d          = instr_rd;
            wide_d        = instr_wide;
            flags_en_d    = instr_flags_en;
        end
        if (wb_active && flags_en_q) begin
            sreg_d[SREG_C] = alu_co;
            sreg_d[SREG_Z] = alu_zo;
            sreg_d[SREG_N] = alu_no;
        end
    end

    always_comb begin
        instr_ready = (state_q == IDLE) && !rst;
        accept      = instr_valid && instr_ready;
        wb_active   = (state_q == WB);
        done        = wb_active;
    end

    assign alu_data_rd = alu_data_rd_q;
    assign alu_data_rr = alu_data_rr_q;
    assign alu_ci      = alu_ci_q;
    assign alu_opcode  = alu_opcode_q;
    assign dbg_sreg    = sreg_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a registered ALU stand-in, a
// transaction-level reference model, and directed scenarios.
module tb_alu_issue_ctrl;

    localparam int ALU_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  instr_op = '0;
    logic [4:0]  instr_rd = '0;
    logic [4:0]  instr_rr = '0;
    logic        instr_wide = 1'b0;
    logic        instr_flags_en = 1'b0;
    logic [7:0]  alu_data_rd;
    logic [7:0]  alu_data_rr;
    logic        alu_ci;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_data_o = '0;
    logic        alu_co = 1'b0;
    logic        alu_zo = 1'b0;
    logic        alu_no = 1'b0;
    logic        done;
    logic        ext_we = 1'b0;
    logic [4:0]  ext_waddr = '0;
    logic [7:0]  ext_wdata = '0;
    logic [4:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;
    logic [2:0]  dbg_sreg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    alu_issue_ctrl #(
        .ALU_LAT (ALU_LAT),
        .NREGS   (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_rd       (instr_rd),
        .instr_rr       (instr_rr),
        .instr_wide     (instr_wide),
        .instr_flags_en (instr_flags_en),
        .alu_data_rd    (alu_data_rd),
        .alu_data_rr    (alu_data_rr),
        .alu_ci         (alu_ci),
        .alu_opcode     (alu_opcode),
        .alu_data_o     (alu_data_o),
        .alu_co         (alu_co),
        .alu_zo         (alu_zo),
        .alu_no         (alu_no),
        .done           (done),
        .ext_we         (ext_we),
        .ext_waddr      (ext_waddr),
        .ext_wdata      (ext_wdata),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data),
        .dbg_sreg       (dbg_sreg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Opcode semantics for the stand-in ALU: returns {co, zo, no, data[15:0]}
    function automatic logic [18:0] aluRef(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic ci);
        logic [8:0]  s;
        logic [15:0] p;
        logic [18:0] r;
        r = '0;
        case (op)
            8'h01: begin
                s = {1'b0, a} + {1'b0, b} + {8'h00, ci};
                r = {s[8], (s[7:0] == 8'h00), s[7], 8'h00, s[7:0]};
            end
            8'h02: begin
                p = {8'h00, a} * {8'h00, b};
                r = {1'b0, (p == 16'h0000), p[15], p};
            end
            8'h03: begin
                s = {1'b0, a} - {1'b0, b};
                r = {s[8], (s[7:0] == 8'h00), s[7], 8'h00, s[7:0]};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        {alu_co, alu_zo, alu_no, alu_data_o} <= aluRef(alu_opcode, alu_data_rd, alu_data_rr, alu_ci);
    end

    // Reference model: mbusy counts cycles left until the instruction retires
    logic [7:0]  mregs [32];
    logic [2:0]  msreg = '0;
    int          mbusy = 0;
    int          m_rd = 0;
    logic        m_wide = 1'b0;
    logic        m_fe = 1'b0;
    logic [18:0] m_res = '0;
    logic [7:0]  m_alu_rd = '0;
    logic [7:0]  m_alu_rr = '0;
    logic        m_alu_ci = 1'b0;
    logic [7:0]  m_alu_op = '0;

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = '0;
            msreg = '0; mbusy = 0; m_rd = 0; m_wide = 0; m_fe = 0; m_res = '0;
            m_alu_rd = '0; m_alu_rr = '0; m_alu_ci = 0; m_alu_op = '0;
        end else begin
            bit retire;
            bit take;
            retire = (mbusy == 1);
            take   = (mbusy == 0) && instr_valid;
            if (take) begin
                m_alu_rd = mregs[instr_rd];
                m_alu_rr = mregs[instr_rr];
                m_alu_ci = msreg[0];
                m_alu_op = instr_op;
                m_rd     = int'(instr_rd);
                m_wide   = instr_wide;
                m_fe     = instr_flags_en;
                m_res    = aluRef(instr_op, m_alu_rd, m_alu_rr, m_alu_ci);
                mbusy    = ALU_LAT + 1;
            end else if (mbusy > 0) begin
                mbusy = mbusy - 1;
            end
            if (ext_we) mregs[ext_waddr] = ext_wdata;
            if (retire) begin
                mregs[m_rd] = m_res[7:0];
                if (m_wide) mregs[(m_rd + 1) % 32] = m_res[15:8];
                if (m_fe) msreg = {m_res[16], m_res[17], m_res[18]};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cyc_ready", 16'(instr_ready), 16'((mbusy == 0) && !rst));
        checkOutput("cyc_done", 16'(done), 16'((mbusy == 1) && !rst));
        checkOutput("cyc_alu_rd", 16'(alu_data_rd), 16'(m_alu_rd));
        checkOutput("cyc_alu_rr", 16'(alu_data_rr), 16'(m_alu_rr));
        checkOutput("cyc_alu_ci", 16'(alu_ci), 16'(m_alu_ci));
        checkOutput("cyc_alu_op", 16'(alu_opcode), 16'(m_alu_op));
        checkOutput("cyc_dbg_data", 16'(dbg_data), 16'(mregs[dbg_addr]));
        checkOutput("cyc_dbg_sreg", 16'(dbg_sreg), 16'(msreg));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic extWrite(input logic [4:0] addr, input logic [7:0] data);
        ext_we = 1'b1; ext_waddr = addr; ext_wdata = data;
        tick();
        ext_we = 1'b0;
    endtask

    task automatic checkReg(input string name, input logic [4:0] addr, input logic [7:0] expected);
        dbg_addr = addr;
        #1;
        checkOutput(name, 16'(dbg_data), 16'(expected));
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] rr,
                                 input logic wide, input logic fe, input logic hold, output int acc);
        int n;
        instr_op = op; instr_rd = rd; instr_rr = rr; instr_wide = wide; instr_flags_en = fe;
        instr_valid = 1'b1;
        n = 0;
        acc = 0;
        forever begin
            @(negedge clk);
            if (instr_ready) break;
            n++;
            if (n > 20) break;
        end
        if (n > 20) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept within 20 cycles");
        end
        @(posedge clk);
        acc = cyc;
        #2;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic waitDone(output int dcyc);
        int n;
        n = 0;
        dcyc = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 20) break;
        end
        if (n > 20) begin
            checks++; errors++;
            $display("[TB] FAIL done_timeout: got no done expected done within 20 cycles");
        end
        dcyc = cyc;
    endtask

    initial begin
        int acc, acc_prev, dcyc;

        // Scenario 1: reset, then reset in the middle of an instruction
        tick(); tick();
        rst = 1'b0;
        tick();
        extWrite(5'd1, 8'h10);
        checkReg("preload_r1", 5'd1, 8'h10);
        applyStimulus(8'h01, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0, acc);
        rst = 1'b1;
        #1;
        checkOutput("rst_ready_low", 16'(instr_ready), 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_no_done", 16'(done), 16'h0);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) checkReg("rst_reg_zero", 5'(i), 8'h00);
        checkOutput("rst_sreg", 16'(dbg_sreg), 16'h0);
        checkOutput("rst_ready_high", 16'(instr_ready), 16'h1);

        // Scenario 2: ADD with flags, latency
        extWrite(5'd2, 8'hF0);
        extWrite(5'd3, 8'h20);
        applyStimulus(8'h01, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, acc);
        waitDone(dcyc);
        checkOutput("add_latency", 16'(dcyc - acc), 16'(ALU_LAT + 1));
        tick();
        checkReg("add_r2", 5'd2, 8'h10);
        checkOutput("add_sreg", 16'(dbg_sreg), 16'b001);

        // Scenario 3: wide MUL, then wide MUL wrapping to r0
        extWrite(5'd4, 8'h0C);
        extWrite(5'd5, 8'h0B);
        applyStimulus(8'h02, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, acc);
        waitDone(dcyc);
        tick();
        checkReg("mul_r4", 5'd4, 8'h84);
        checkReg("mul_r5", 5'd5, 8'h00);
        extWrite(5'd31, 8'h0C);
        applyStimulus(8'h02, 5'd31, 5'd3, 1'b1, 1'b0, 1'b0, acc);
        waitDone(dcyc);
        tick();
        checkReg("mulw_r31", 5'd31, 8'h80);
        checkReg("mulw_r0", 5'd0, 8'h01);
        checkOutput("mulw_sreg_kept", 16'(dbg_sreg), 16'b001);

        // Scenario 4: carry-in use, then SUB to zero
        extWrite(5'd6, 8'h01);
        extWrite(5'd7, 8'h01);
        applyStimulus(8'h01, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, acc);
        checkOutput("adc_alu_ci", 16'(alu_ci), 16'h1);
        waitDone(dcyc);
        tick();
        checkReg("adc_r6", 5'd6, 8'h03);
        applyStimulus(8'h03, 5'd6, 5'd6, 1'b0, 1'b1, 1'b0, acc);
        waitDone(dcyc);
        tick();
        checkReg("sub_r6", 5'd6, 8'h00);
        checkOutput("sub_sreg", 16'(dbg_sreg), 16'b010);

        // Scenario 5: back-to-back with valid held and junk while busy
        extWrite(5'd8, 8'h01);
        extWrite(5'd9, 8'h02);
        acc_prev = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h01, 5'd8, 5'd9, 1'b0, 1'b0, 1'b1, acc);
            if (i > 0) checkOutput("b2b_spacing", 16'(acc - acc_prev), 16'(ALU_LAT + 2));
            acc_prev = acc;
            instr_op = 8'h02; instr_rd = 5'd20; instr_rr = 5'd9; instr_wide = 1'b1; instr_flags_en = 1'b1;
            #1;
            checkOutput("b2b_busy_ready", 16'(instr_ready), 16'h0);
            tick();
        end
        instr_valid = 1'b0;
        waitDone(dcyc);
        tick();
        checkReg("b2b_r8", 5'd8, 8'h07);
        checkReg("b2b_r20", 5'd20, 8'h00);
        checkOutput("b2b_sreg", 16'(dbg_sreg), 16'b010);

        // Scenario 6: ext writes on the write-back edge
        extWrite(5'd10, 8'h05);
        extWrite(5'd11, 8'h06);
        applyStimulus(8'h01, 5'd10, 5'd11, 1'b0, 1'b0, 1'b0, acc);
        waitDone(dcyc);
        #1;
        ext_we = 1'b1; ext_waddr = 5'd10; ext_wdata = 8'hAA;
        tick();
        ext_we = 1'b0;
        checkReg("coll_r10", 5'd10, 8'h0B);
        extWrite(5'd12, 8'h01);
        extWrite(5'd13, 8'h01);
        applyStimulus(8'h01, 5'd12, 5'd13, 1'b0, 1'b0, 1'b0, acc);
        waitDone(dcyc);
        #1;
        ext_we = 1'b1; ext_waddr = 5'd14; ext_wdata = 8'h55;
        tick();
        ext_we = 1'b0;
        checkReg("nocoll_r12", 5'd12, 8'h02);
        checkReg("nocoll_r14", 5'd14, 8'h55);

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
